bet_input_conditioner: RTL and testbench

BET_INPUT_CONDITIONER -- requirements
Module: bet_input_conditioner

---
 rtl/bet_input_conditioner_pkg.sv | 15 +
 rtl/bet_input_conditioner_key_debouncer.sv | 50 +++++
 rtl/bet_input_conditioner.sv | 126 ++++++++++++
 tb/tb_bet_input_conditioner.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bet_input_conditioner_pkg.sv
// Shared constants and state type for the bet entry front end.
package bet_input_conditioner_pkg;

    localparam int DIGIT_W        = 4;
    localparam int BET_MAX_DIGITS = 5;

    localparam logic [DIGIT_W-1:0] MAX_DIGIT_VALUE = 4'd9;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_READY   = 2'd1,
        ST_DONE    = 2'd2
    } bet_state_e;

endpackage

// File: rtl/bet_input_conditioner_key_debouncer.sv
// Debounces one synchronized active-low key and emits a one-cycle press
// event when the debounced level falls. Releases produce no event.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n_i,
    output logic press_o
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    // Count consecutive cycles of disagreement; any agreement restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (key_n_i != level_q) begin
            if (cnt_q == CNT_TC) begin
                level_d = key_n_i;
                press_d = ~key_n_i;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // Debounced level starts released; press event is registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/bet_input_conditioner.sv
// Bet entry front end: synchronizes the digit switches and the two keys,
// debounces the keys, and runs the digit collection sequence that feeds
// the downstream lottery FSM.
module bet_input_conditioner
    import bet_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MAX_DIGITS      = BET_MAX_DIGITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DIGIT_W-1:0] sw_num,
    input  logic               key_insert_n,
    input  logic               key_finish_n,
    output logic [DIGIT_W-1:0] num,
    output logic               insert,
    output logic               finish,
    output logic [2:0]         digit_count,
    output logic               entry_error
);

    localparam logic [2:0] LAST_DIGIT_IDX = 3'(MAX_DIGITS - 1);
    localparam logic [2:0] COUNT_ONE      = 3'd1;

    logic [DIGIT_W-1:0] sw_meta_q, sw_sync_q;
    logic               ins_meta_q, ins_sync_q;
    logic               fin_meta_q, fin_sync_q;
    logic               ins_press, fin_press;

    bet_state_e         state_q;
    logic [DIGIT_W-1:0] num_q;
    logic               insert_q;
    logic               finish_q;
    logic [2:0]         count_q;
    logic               error_q;

    // Two-flop synchronizers; keys come out of reset released.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            ins_meta_q <= 1'b1;
            ins_sync_q <= 1'b1;
            fin_meta_q <= 1'b1;
            fin_sync_q <= 1'b1;
        end else begin
            sw_meta_q  <= sw_num;
            sw_sync_q  <= sw_meta_q;
            ins_meta_q <= key_insert_n;
            ins_sync_q <= ins_meta_q;
            fin_meta_q <= key_finish_n;
            fin_sync_q <= fin_meta_q;
        end
    end

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_insert_db (
        .clk     (clk),
        .reset   (reset),
        .key_n_i (ins_sync_q),
        .press_o (ins_press)
    );

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_finish_db (
        .clk     (clk),
        .reset   (reset),
        .key_n_i (fin_sync_q),
        .press_o (fin_press)
    );

    // Digit collection FSM with registered outputs. Finish is only honoured
    // in READY, so a simultaneous insert in COLLECT always wins over finish,
    // and in READY the ignored insert does not block the finish request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_COLLECT;
            num_q    <= '0;
            insert_q <= 1'b0;
            finish_q <= 1'b0;
            count_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            insert_q <= 1'b0;
            finish_q <= 1'b0;
            case (state_q)
                ST_COLLECT: begin
                    if (ins_press) begin
                        if (sw_sync_q <= MAX_DIGIT_VALUE) begin
                            num_q    <= sw_sync_q;
                            insert_q <= 1'b1;
                            count_q  <= count_q + COUNT_ONE;
                            error_q  <= 1'b0;
                            if (count_q == LAST_DIGIT_IDX) begin
                                state_q <= ST_READY;
                            end
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                ST_READY: begin
                    if (fin_press) begin
                        finish_q <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_COLLECT;
                end
            endcase
        end
    end

    assign num         = num_q;
    assign insert      = insert_q;
    assign finish      = finish_q;
    assign digit_count = count_q;
    assign entry_error = error_q;

endmodule

// File: tb/tb_bet_input_conditioner.sv
// Bench for bet_input_conditioner with a short debounce window.
module tb_bet_input_conditioner;

    localparam int DB   = 4;
    localparam int MAXD = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] sw_num = 4'd0;
    logic       key_insert_n = 1'b1;
    logic       key_finish_n = 1'b1;
    logic [3:0] num;
    logic       insert;
    logic       finish;
    logic [2:0] digit_count;
    logic       entry_error;

    int n_checks = 0;
    int n_fail   = 0;
    int ins_pulses = 0;
    int fin_pulses = 0;
    int overlap    = 0;
    int last_ins_num = -1;

    typedef struct {
        bit         rst;
        logic [3:0] sw;
        bit         ins;
        bit         fin;
        int         e_ins;
        int         e_fin;
        int         e_num;
        int         e_cnt;
        int         e_err;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    bet_input_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .MAX_DIGITS      (MAXD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sw_num       (sw_num),
        .key_insert_n (key_insert_n),
        .key_finish_n (key_finish_n),
        .num          (num),
        .insert       (insert),
        .finish       (finish),
        .digit_count  (digit_count),
        .entry_error  (entry_error)
    );

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (insert) begin
            ins_pulses++;
            last_ins_num = int'(num);
        end
        if (finish) fin_pulses++;
        if (insert && finish) overlap++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        key_insert_n = 1'b1;
        key_finish_n = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic set_keys(input bit ins, input bit fin, input bit down);
        key_insert_n = (ins && down) ? 1'b0 : 1'b1;
        key_finish_n = (fin && down) ? 1'b0 : 1'b1;
    endtask

    // One clean press (optionally preceded by short bounces) and release.
    task automatic press_op(input logic [3:0] sw, input bit ins, input bit fin,
                            input int bounces);
        @(negedge clk);
        sw_num = sw;
        repeat (3) @(negedge clk);
        for (int b = 0; b < bounces; b++) begin
            set_keys(ins, fin, 1'b1);
            repeat ($urandom_range(1, DB - 1)) @(negedge clk);
            set_keys(ins, fin, 1'b0);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        set_keys(ins, fin, 1'b1);
        repeat (DB + 8) @(negedge clk);
        set_keys(ins, fin, 1'b0);
        repeat (DB + 8) @(negedge clk);
    endtask

    task automatic check_state(input string tag, input int d_ins, input int d_fin,
                               input int e_ins, input int e_fin, input int e_num,
                               input int e_cnt, input int e_err);
        check({tag, " insert pulses"}, d_ins, e_ins);
        check({tag, " finish pulses"}, d_fin, e_fin);
        check({tag, " num"}, int'(num), e_num);
        check({tag, " digit_count"}, int'(digit_count), e_cnt);
        check({tag, " entry_error"}, int'(entry_error), e_err);
    endtask

    function automatic vec_t mk(bit rst, int sw, bit ins, bit fin, int ei, int ef,
                                int en, int ec, int ee);
        vec_t v;
        v.rst = rst; v.sw = 4'(sw); v.ins = ins; v.fin = fin;
        v.e_ins = ei; v.e_fin = ef; v.e_num = en; v.e_cnt = ec; v.e_err = ee;
        return v;
    endfunction

    initial begin
        int i0, f0, lat;
        int m_cnt, m_num, m_err, m_done;

        // Reset state
        do_reset();
        check("reset num", int'(num), 0);
        check("reset insert", int'(insert), 0);
        check("reset finish", int'(finish), 0);
        check("reset digit_count", int'(digit_count), 0);
        check("reset entry_error", int'(entry_error), 0);

        // Bouncy insert key: single pulse, 2 + DB + 1 edges after stable low
        sw_num = 4'd5;
        repeat (3) @(negedge clk);
        i0 = ins_pulses;
        for (int b = 0; b < 5; b++) begin
            key_insert_n = 1'b0;
            @(negedge clk);
            key_insert_n = 1'b1;
            @(negedge clk);
        end
        key_insert_n = 1'b0;
        lat = -1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            if (insert && lat < 0) lat = k;
        end
        @(negedge clk);
        key_insert_n = 1'b1;
        repeat (DB + 8) @(negedge clk);
        check("bounce latency", lat, 2 + DB + 1);
        check("bounce pulse count", ins_pulses - i0, 1);
        check("bounce num", int'(num), 5);

        // Directed bet sequences
        vecs.push_back(mk(1,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0,  5, 1, 0, 1, 0, 5, 1, 0));
        vecs.push_back(mk(0,  0, 1, 0, 1, 0, 0, 2, 0));
        vecs.push_back(mk(0,  9, 1, 0, 1, 0, 9, 3, 0));
        vecs.push_back(mk(0,  6, 1, 0, 1, 0, 6, 4, 0));
        vecs.push_back(mk(0,  7, 1, 0, 1, 0, 7, 5, 0));
        vecs.push_back(mk(0,  2, 1, 0, 0, 0, 7, 5, 0));
        vecs.push_back(mk(0,  2, 0, 1, 0, 1, 7, 5, 0));
        vecs.push_back(mk(0,  2, 0, 1, 0, 0, 7, 5, 0));
        vecs.push_back(mk(0,  3, 1, 0, 0, 0, 7, 5, 0));
        vecs.push_back(mk(1,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 12, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0,  3, 1, 0, 1, 0, 3, 1, 0));
        vecs.push_back(mk(0,  7, 0, 1, 0, 0, 3, 1, 0));
        vecs.push_back(mk(0,  8, 1, 1, 1, 0, 8, 2, 0));
        vecs.push_back(mk(0, 15, 1, 0, 0, 0, 8, 2, 1));
        vecs.push_back(mk(0,  0, 1, 0, 1, 0, 0, 3, 0));
        vecs.push_back(mk(0,  4, 0, 1, 0, 0, 0, 3, 0));
        vecs.push_back(mk(0,  9, 1, 0, 1, 0, 9, 4, 0));
        vecs.push_back(mk(0, 10, 1, 0, 0, 0, 9, 4, 1));
        vecs.push_back(mk(0,  4, 1, 0, 1, 0, 4, 5, 0));
        vecs.push_back(mk(0, 11, 1, 0, 0, 0, 4, 5, 0));
        vecs.push_back(mk(0,  1, 0, 1, 0, 1, 4, 5, 0));
        vecs.push_back(mk(0,  1, 0, 1, 0, 0, 4, 5, 0));
        vecs.push_back(mk(0,  2, 1, 1, 0, 0, 4, 5, 0));

        for (int v = 0; v < vecs.size(); v++) begin
            i0 = ins_pulses;
            f0 = fin_pulses;
            if (vecs[v].rst) do_reset();
            else press_op(vecs[v].sw, vecs[v].ins, vecs[v].fin, v % 3);
            check_state($sformatf("vec%0d", v), ins_pulses - i0, fin_pulses - f0,
                        vecs[v].e_ins, vecs[v].e_fin, vecs[v].e_num,
                        vecs[v].e_cnt, vecs[v].e_err);
            if (vecs[v].e_ins == 1)
                check($sformatf("vec%0d pulse num", v), last_ins_num, vecs[v].e_num);
        end

        // Reset after three digits with an insert press mid-debounce
        do_reset();
        press_op(4'd1, 1'b1, 1'b0, 0);
        press_op(4'd2, 1'b1, 1'b0, 0);
        press_op(4'd3, 1'b1, 1'b0, 0);
        check("midreset pre count", int'(digit_count), 3);
        @(negedge clk);
        sw_num = 4'd4;
        key_insert_n = 1'b0;
        repeat (5) @(negedge clk);
        i0 = ins_pulses;
        reset = 1'b1;
        key_insert_n = 1'b1;
        @(negedge clk);
        check_state("midreset in reset", 0, 0, 0, 0, 0, 0, 0);
        check("midreset insert out", int'(insert), 0);
        check("midreset finish out", int'(finish), 0);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check_state("midreset after", ins_pulses - i0, 0, 0, 0, 0, 0, 0);
        i0 = ins_pulses;
        press_op(4'd6, 1'b1, 1'b0, 1);
        check_state("midreset fresh", ins_pulses - i0, 0, 1, 0, 6, 1, 0);

        // Randomized operations against a bet-rule model
        do_reset();
        m_cnt = 0; m_num = 0; m_err = 0; m_done = 0;
        for (int r = 0; r < 40; r++) begin
            bit         rst, ins, fin;
            int         kind, e_ins, e_fin;
            logic [3:0] sw;
            rst  = ($urandom_range(0, 14) == 0);
            kind = $urandom_range(0, 5);
            ins  = (kind <= 2) || (kind == 5);
            fin  = (kind >= 3);
            sw   = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 9))
                                               : 4'($urandom_range(10, 15));
            e_ins = 0;
            e_fin = 0;
            if (rst) begin
                m_cnt = 0; m_num = 0; m_err = 0; m_done = 0;
            end else if (m_cnt < MAXD) begin
                if (ins) begin
                    if (int'(sw) <= 9) begin
                        m_num = int'(sw); m_cnt++; m_err = 0; e_ins = 1;
                    end else begin
                        m_err = 1;
                    end
                end
            end else if (!m_done && fin) begin
                e_fin = 1;
                m_done = 1;
            end
            i0 = ins_pulses;
            f0 = fin_pulses;
            if (rst) do_reset();
            else press_op(sw, ins, fin, $urandom_range(0, 2));
            check_state($sformatf("rand%0d", r), ins_pulses - i0, fin_pulses - f0,
                        e_ins, e_fin, m_num, m_cnt, m_err);
        end

        check("insert/finish overlap cycles", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
